// File: rtl/compare_unit_pkg.sv
// Shared definitions for the registered compare unit.
package compare_unit_pkg;

   localparam int unsigned CMP_WIDTH_DEFAULT = 4;

   // One-hot-when-valid compare outcome.
   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_result_t;

endpackage : compare_unit_pkg

// File: rtl/compare_unit_core.sv
// Combinational magnitude compare of a against b, signed or unsigned.
module compare_core #(
   parameter int unsigned WIDTH  = 4,
   parameter bit          SIGNED = 1'b1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   logic sign_diff;
   logic ult;
   logic ugt;

   assign ult       = (a < b);
   assign ugt       = (a > b);
   assign sign_diff = SIGNED && (a[WIDTH-1] != b[WIDTH-1]);

   // When signs differ the negative operand is the smaller; otherwise the
   // unsigned order of the bit patterns matches the signed order.
   always_comb begin
      eq = (a == b);
      if (sign_diff) begin
         lt = a[WIDTH-1];
         gt = b[WIDTH-1];
      end else begin
         lt = ult;
         gt = ugt;
      end
   end

endmodule : compare_core

// File: rtl/compare_unit.sv
// Registered comparator: one-cycle latency lt/eq/gt flags plus valid strobe.
module compare_unit
   import compare_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = CMP_WIDTH_DEFAULT,
   parameter bit          SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out,
   output logic             eq,
   output logic             gt,
   output logic             out_valid
);

   cmp_result_t res_d;
   cmp_result_t res_q;
   logic        valid_q;

   compare_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .a  (in1),
      .b  (in2),
      .lt (res_d.lt),
      .eq (res_d.eq),
      .gt (res_d.gt)
   );

   // Result register: reset clears, valid captures, otherwise flags hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else if (in_valid) begin
         res_q   <= res_d;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign out       = res_q.lt;
   assign eq        = res_q.eq;
   assign gt        = res_q.gt;
   assign out_valid = valid_q;

endmodule : compare_unit

// File: tb/tb_compare_unit.sv
// Self-checking bench: signed and unsigned compare_unit against an integer model.
module tb_compare_unit;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in1;
   logic [W-1:0] in2;

   logic s_out, s_eq, s_gt, s_vld;
   logic u_out, u_eq, u_gt, u_vld;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: index 0 = signed instance, 1 = unsigned instance.
   logic m_lt [2];
   logic m_eq [2];
   logic m_gt [2];
   logic m_v;

   always #5 clk = ~clk;

   compare_unit #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .out       (s_out),
      .eq        (s_eq),
      .gt        (s_gt),
      .out_valid (s_vld)
   );

   compare_unit #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .out       (u_out),
      .eq        (u_eq),
      .gt        (u_gt),
      .out_valid (u_vld)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (in1=%b in2=%b)", tag, got, exp, in1, in2);
   endtask

   // Numeric value of a bit pattern under the chosen interpretation.
   function automatic int value_of(input logic [W-1:0] x, input bit sgn);
      int v;
      v = int'(x);
      if (sgn && v >= (1 << (W - 1))) v = v - (1 << W);
      return v;
   endfunction

   // Drive one cycle of stimulus, advance the model at the edge, then check.
   task automatic apply(input logic rst, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      int va, vb;
      reset    = rst;
      in_valid = v;
      in1      = a;
      in2      = b;
      @(posedge clk);
      if (rst) begin
         for (int unsigned k = 0; k < 2; k++) begin
            m_lt[k] = 1'b0; m_eq[k] = 1'b0; m_gt[k] = 1'b0;
         end
         m_v = 1'b0;
      end else if (v) begin
         for (int unsigned k = 0; k < 2; k++) begin
            va = value_of(a, (k == 0));
            vb = value_of(b, (k == 0));
            m_lt[k] = (va < vb);
            m_eq[k] = (va == vb);
            m_gt[k] = (va > vb);
         end
         m_v = 1'b1;
      end else begin
         m_v = 1'b0;
      end
      #1;
      check("s_out", int'(s_out), int'(m_lt[0]));
      check("s_eq",  int'(s_eq),  int'(m_eq[0]));
      check("s_gt",  int'(s_gt),  int'(m_gt[0]));
      check("s_vld", int'(s_vld), int'(m_v));
      check("u_out", int'(u_out), int'(m_lt[1]));
      check("u_eq",  int'(u_eq),  int'(m_eq[1]));
      check("u_gt",  int'(u_gt),  int'(m_gt[1]));
      check("u_vld", int'(u_vld), int'(m_v));
      if (m_v) begin
         check("s_onehot", $countones({s_out, s_eq, s_gt}), 1);
         check("u_onehot", $countones({u_out, u_eq, u_gt}), 1);
      end
   endtask

   initial begin
      logic [7:0] pair;
      reset = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
      m_v = 1'b0;

      // Reset has priority over a valid input.
      apply(1'b1, 1'b1, 4'b0001, 4'b0010);
      apply(1'b1, 1'b1, 4'b0001, 4'b0010);
      apply(1'b0, 1'b1, 4'b0001, 4'b0010);

      // Directed signed and sign-boundary cases.
      apply(1'b0, 1'b1, 4'b1100, 4'b1101);
      apply(1'b0, 1'b1, 4'b1000, 4'b1101);
      apply(1'b0, 1'b1, 4'b1000, 4'b0111);
      apply(1'b0, 1'b1, 4'b0111, 4'b1000);
      apply(1'b0, 1'b1, 4'b1111, 4'b0000);

      // Equality then hold with changed inputs.
      apply(1'b0, 1'b1, 4'b0101, 4'b0101);
      apply(1'b0, 1'b0, 4'b1000, 4'b0001);
      apply(1'b0, 1'b0, 4'b0001, 4'b1110);

      // Exhaustive back-to-back stream with one mid-stream reset.
      for (int i = 0; i < 256; i++) begin
         pair = 8'(i);
         apply((i == 100), 1'b1, pair[7:4], pair[3:0]);
      end

      // Randomised traffic: sparse valids and occasional resets.
      for (int i = 0; i < 300; i++) begin
         apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               W'($urandom), W'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_compare_unit

// File: doc/compare_unit.md
Name: compare_unit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands; primary result `out` = 1 iff in1 < in2.
- Comparison is two's-complement signed by default. An unsigned mode is selected by parameter.
- Also reports eq/gt flags and a valid strobe.
- Sits in datapath/ALU-side logic wherever a single-bit "less-than" decision is needed (slt-style).

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32).
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled only on the rising clk edge.
- in_valid  input  1  operands on in1/in2 are valid this cycle.
- in1  input  WIDTH  first operand.
- in2  input  WIDTH  second operand.
- out  output  1  registered: 1 iff in1 < in2 under the selected signedness.
- eq  output  1  registered: 1 iff in1 == in2 (bitwise).
- gt  output  1  registered: 1 iff in1 > in2 under the selected signedness.
- out_valid  output  1  registered: high the cycle after in_valid was sampled high.

Behaviour:
- Reset: on a rising edge with reset=1, out, eq, gt and out_valid are all cleared to 0. Reset has priority over in_valid.
- Latency is 1 cycle. On a rising edge with reset=0 and in_valid=1, out/eq/gt capture the compare of the in1/in2 values present at that edge, and out_valid goes to 1.
- On a rising edge with reset=0 and in_valid=0: out_valid goes to 0, and out/eq/gt hold their previous values.
- No backpressure. A new result may be produced every cycle.
- Exactly one of out/eq/gt is 1 whenever out_valid=1. After reset all three are 0, which is the only state where none is 1.
- Signed mode: the MSB is the sign bit. Implement as in1 < in2 ⇔ (sign differs ? in1[MSB] : unsigned(in1) < unsigned(in2)).
- Unsigned mode: plain binary compare.
- Boundary cases for WIDTH=4, signed mode:
  - 1000 (-8) < 0111 (+7) → out=1.
  - 0111 < 1000 → out=0, gt=1.
  - 1111 (-1) < 0000 → out=1.
  - Equal operands → eq=1, out=0, gt=0.
- Inputs are treated as combinationally stable around the clk edge. Input X/Z values are outside scope.
- Reset asserted mid-stream clears the pending result in the same edge. The first valid result after reset deassertion requires a new in_valid.

Decomposition:
- Shared package holds:
  - CMP_WIDTH_DEFAULT = 4.
  - A cmp_result_t struct/typedef {lt, eq, gt}.
- One natural combinational sub-module, compare_core. It has parameters WIDTH and SIGNED, inputs a and b, and outputs lt, eq, gt.
- compare_unit wraps compare_core with the valid pipeline register and the reset logic.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1, in1=0001, in2=0010 → out=eq=gt=out_valid=0 throughout. The first edge after release yields out=1.
- Signed ordinary: in1=1100 (-4), in2=1101 (-3), in_valid=1 → next cycle out=1, eq=0, gt=0, out_valid=1.
- Sign-boundary: in1=1000, in2=1101 → out=1. Then in1=1000, in2=0111 → out=1 (signed). The same pair with SIGNED=0 → out=0, gt=1.
- Equality and hold: in1=in2=0101 → eq=1, out=0. Then in_valid=0 with changed inputs → out_valid=0 and flags unchanged.
- Back-to-back: stream all 256 (in1,in2) pairs with in_valid=1 every cycle. Each result appears exactly 1 cycle later and matches a signed reference model; exactly one flag is set per result.
- Mid-stream reset: assert reset for one edge during streaming → that edge outputs are all 0. The stream resumes correctly on the next valid edge.
